// File: rtl/jtkiwi_sdram_arb.sv
// jtkiwi_sdram_arb
// Two-requester round-robin arbiter in front of one shared SDRAM read slot.
// Each requester (scroll layer and object layer) owns a one-entry result
// buffer (valid, data, tag). A requester whose current address matches its
// buffer tag is served straight from the buffer; otherwise it is pending and
// competes for the SDRAM slot.
//
// Ports
//   clk                 single clock
//   rst                 synchronous, active-high reset
//   scr_cs/scr_addr     scroll requester strobe and word address
//   scr_data/scr_ok     scroll result data and hit indication
//   obj_cs/obj_addr     object requester strobe and word address
//   obj_data/obj_ok     object result data and hit indication
//   ram_cs/ram_addr     SDRAM slot request and latched word address
//   ram_data/ram_ok     SDRAM slot read data and completion strobe
//   busy                high whenever an access is in flight (not IDLE)
module jtkiwi_sdram_arb #(
  parameter int AW        = 18,
  parameter bit OBJ_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  input  logic [31:0]   ram_data,
  input  logic          ram_ok,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          ram_cs_r, ram_cs_s;
  logic [AW-1:0] ram_addr_r, ram_addr_s;
  logic          gnt_obj_r, gnt_obj_s;    // current access belongs to obj
  logic          last_obj_r, last_obj_s;  // previous grant went to obj
  logic          wr_scr_s, wr_obj_s;

  logic          scr_valid_r, obj_valid_r;
  logic [31:0]   scr_data_r, obj_data_r;
  logic [AW-1:0] scr_tag_r, obj_tag_r;

  logic          scr_match_s, obj_match_s;
  logic          scr_pend_s, obj_pend_s;

  // Full-width tag compare; a requester is pending when its buffer misses.
  always_comb begin
    scr_match_s = scr_valid_r & (scr_addr == scr_tag_r);
    obj_match_s = obj_valid_r & (obj_addr == obj_tag_r);
    scr_pend_s  = scr_cs & ~scr_match_s;
    obj_pend_s  = obj_cs & ~obj_match_s;
  end

  assign scr_ok   = scr_cs & scr_match_s;
  assign obj_ok   = obj_cs & obj_match_s;
  assign scr_data = scr_data_r;
  assign obj_data = obj_data_r;
  assign ram_cs   = ram_cs_r;
  assign ram_addr = ram_addr_r;
  assign busy     = (state_r != IDLE);

  // Next-state and slot-control logic for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_s    = state_r;
    ram_cs_s   = ram_cs_r;
    ram_addr_s = ram_addr_r;
    gnt_obj_s  = gnt_obj_r;
    last_obj_s = last_obj_r;
    wr_scr_s   = 1'b0;
    wr_obj_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (scr_pend_s || obj_pend_s) begin
          // On a tie the side that lost last time wins
          if (scr_pend_s && obj_pend_s) begin
            gnt_obj_s = ~last_obj_r;
          end else begin
            gnt_obj_s = obj_pend_s;
          end
          last_obj_s = gnt_obj_s;
          ram_addr_s = gnt_obj_s ? obj_addr : scr_addr;
          ram_cs_s   = 1'b1;
          state_s    = ISSUE;
        end else begin
          ram_cs_s = 1'b0;
          state_s  = IDLE;
        end
      end
      ISSUE: begin
        // ram_ok here still belongs to the previous access, so ignore it
        ram_cs_s = 1'b1;
        state_s  = WAIT;
      end
      WAIT: begin
        if (ram_ok) begin
          // Completion is written even if the requester moved on meanwhile
          wr_obj_s = gnt_obj_r;
          wr_scr_s = ~gnt_obj_r;
          ram_cs_s = 1'b0;
          state_s  = IDLE;
        end else begin
          ram_cs_s = 1'b1;
          state_s  = WAIT;
        end
      end
      default: begin
        ram_cs_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // Arbiter state and SDRAM slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ram_cs_r   <= 1'b0;
      ram_addr_r <= {AW{1'b0}};
      gnt_obj_r  <= 1'b0;
      last_obj_r <= ~OBJ_FIRST;
    end else begin
      state_r    <= state_s;
      ram_cs_r   <= ram_cs_s;
      ram_addr_r <= ram_addr_s;
      gnt_obj_r  <= gnt_obj_s;
      last_obj_r <= last_obj_s;
    end
  end

  // Per-requester result buffers, updated only by their own completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      scr_valid_r <= 1'b0;
      scr_data_r  <= 32'd0;
      scr_tag_r   <= {AW{1'b0}};
      obj_valid_r <= 1'b0;
      obj_data_r  <= 32'd0;
      obj_tag_r   <= {AW{1'b0}};
    end else begin
      if (wr_scr_s) begin
        scr_valid_r <= 1'b1;
        scr_data_r  <= ram_data;
        scr_tag_r   <= ram_addr_r;
      end
      if (wr_obj_s) begin
        obj_valid_r <= 1'b1;
        obj_data_r  <= ram_data;
        obj_tag_r   <= ram_addr_r;
      end
    end
  end

endmodule

// File: tb/tb_jtkiwi_sdram_arb.sv
// Directed testbench for jtkiwi_sdram_arb with address/data scoreboards.
module tb_jtkiwi_sdram_arb;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          scr_cs, obj_cs, ram_ok;
  logic [AW-1:0] scr_addr, obj_addr;
  logic [31:0]   ram_data;
  logic [31:0]   scr_data, obj_data;
  logic          scr_ok, obj_ok, ram_cs, busy;
  logic [AW-1:0] ram_addr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];

  jtkiwi_sdram_arb #(.AW(AW), .OBJ_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ok(ram_ok),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare current ram_addr against the next expected grant address.
  task automatic chk_addr(input string tag);
    logic [AW-1:0] e;
    if (exp_addr_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty address scoreboard expected an entry", tag);
    end else begin
      e = exp_addr_q.pop_front();
      chk(tag, 32'(ram_addr), 32'(e));
    end
  endtask

  // Compare a result data port against the next expected completion.
  task automatic chk_data(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_data_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty data scoreboard expected an entry", tag);
    end else begin
      e = exp_data_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Wait (bounded) for ram_cs, then check the granted address.
  task automatic wait_grant(input string tag);
    int k = 0;
    while (!ram_cs && k < 16) begin
      step();
      k++;
    end
    chk({tag, "_cs"}, 32'(ram_cs), 32'd1);
    if (ram_cs) chk_addr({tag, "_addr"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic expect_obj;
    logic [31:0] d;
    rst = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0; ram_ok = 1'b0;
    scr_addr = 18'h0; obj_addr = 18'h0; ram_data = 32'h0;

    // Reset state
    do_reset();
    chk("rst_scr_ok", 32'(scr_ok), 32'd0);
    chk("rst_obj_ok", 32'(obj_ok), 32'd0);
    chk("rst_scr_data", scr_data, 32'h0);
    chk("rst_obj_data", obj_data, 32'h0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request: cycle 0 request, ram_ok at cycle 4
    scr_cs = 1'b1; scr_addr = 18'h00123;
    exp_addr_q.push_back(18'h00123);
    step();                                  // cycle 1 (ISSUE)
    chk("single_cs_c1", 32'(ram_cs), 32'd1);
    chk_addr("single_addr_c1");
    chk("single_busy", 32'(busy), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("single_cs_wait", 32'(ram_cs), 32'd1);
      chk("single_addr_wait", 32'(ram_addr), 32'h00123);
      chk("single_ok_early", 32'(scr_ok), 32'd0);
    end
    ram_ok = 1'b1; ram_data = 32'hDEADBEEF;
    exp_data_q.push_back(32'hDEADBEEF);
    step();                                  // cycle 5
    ram_ok = 1'b0;
    chk("single_scr_ok", 32'(scr_ok), 32'd1);
    chk_data("single_scr_data", scr_data);
    chk("single_obj_ok", 32'(obj_ok), 32'd0);
    chk("single_cs_drop", 32'(ram_cs), 32'd0);

    // Hit: toggle scr_cs at the same address, no new access
    scr_cs = 1'b0; #1;
    chk("hit_ok_low", 32'(scr_ok), 32'd0);
    step();
    scr_cs = 1'b1; #1;
    chk("hit_ok_high", 32'(scr_ok), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hit_no_cs", 32'(ram_cs), 32'd0);
      chk("hit_ok_hold", 32'(scr_ok), 32'd1);
    end

    // Stale ram_ok held high across IDLE and ISSUE
    ram_ok = 1'b1; ram_data = 32'hAAAA5555;
    scr_addr = 18'h00200;
    exp_addr_q.push_back(18'h00200);
    step();                                  // ISSUE
    chk("stale_cs_issue", 32'(ram_cs), 32'd1);
    chk_addr("stale_addr");
    step();                                  // first WAIT cycle
    chk("stale_cs_wait", 32'(ram_cs), 32'd1);
    chk("stale_ok_early", 32'(scr_ok), 32'd0);
    exp_data_q.push_back(32'hAAAA5555);
    step();
    ram_ok = 1'b0;
    chk("stale_ok", 32'(scr_ok), 32'd1);
    chk_data("stale_data", scr_data);
    chk("stale_cs_drop", 32'(ram_cs), 32'd0);

    // Abandon: obj address changes during WAIT
    scr_cs = 1'b0;
    obj_cs = 1'b1; obj_addr = 18'h00040;
    exp_addr_q.push_back(18'h00040);
    wait_grant("aband_first");
    step();                                  // WAIT
    obj_addr = 18'h00041;
    ram_ok = 1'b1; ram_data = 32'h04040404;
    step();                                  // IDLE
    ram_ok = 1'b0;
    chk("aband_obj_ok", 32'(obj_ok), 32'd0);
    chk("aband_obj_data", obj_data, 32'h04040404);
    chk("aband_cs_drop", 32'(ram_cs), 32'd0);
    chk("aband_busy", 32'(busy), 32'd0);
    chk("aband_scr_data", scr_data, 32'hAAAA5555);
    exp_addr_q.push_back(18'h00041);
    step();                                  // ISSUE after exactly one IDLE
    chk("aband_reissue_cs", 32'(ram_cs), 32'd1);
    chk_addr("aband_reissue_addr");
    step();
    ram_ok = 1'b1; ram_data = 32'h04141414;
    exp_data_q.push_back(32'h04141414);
    step();
    ram_ok = 1'b0;
    chk("aband_new_ok", 32'(obj_ok), 32'd1);
    chk_data("aband_new_data", obj_data);

    // Reset during WAIT, then a late ram_ok
    obj_addr = 18'h00050;
    exp_addr_q.push_back(18'h00050);
    wait_grant("rstw");
    step();                                  // WAIT
    rst = 1'b1; obj_cs = 1'b0;
    step();
    rst = 1'b0;
    ram_ok = 1'b1; ram_data = 32'hFFFF0000;
    chk("rstw_cs", 32'(ram_cs), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_obj_data", obj_data, 32'h0);
    chk("rstw_scr_data", scr_data, 32'h0);
    step();
    step();
    ram_ok = 1'b0;
    chk("rstw_late_busy", 32'(busy), 32'd0);
    chk("rstw_late_cs", 32'(ram_cs), 32'd0);
    chk("rstw_late_data", obj_data, 32'h0);
    obj_cs = 1'b1; #1;
    chk("rstw_obj_ok", 32'(obj_ok), 32'd0);
    obj_cs = 1'b0;

    // Tie after reset, OBJ_FIRST=1, then strict alternation
    do_reset();
    scr_cs = 1'b1; scr_addr = 18'h00010;
    obj_cs = 1'b1; obj_addr = 18'h00020;
    expect_obj = 1'b1;
    for (int g = 0; g < 8; g++) begin
      exp_addr_q.push_back(expect_obj ? obj_addr : scr_addr);
      wait_grant("tie_grant");
      step();                                // WAIT
      d = {16'hC0DE, 16'(g)};
      ram_ok = 1'b1; ram_data = d;
      exp_data_q.push_back(d);
      step();                                // IDLE
      ram_ok = 1'b0;
      chk("tie_cs_gap", 32'(ram_cs), 32'd0);
      if (expect_obj) begin
        chk("tie_obj_ok", 32'(obj_ok), 32'd1);
        chk("tie_scr_idle", 32'(scr_ok), 32'd0);
        chk_data("tie_obj_data", obj_data);
        obj_addr = obj_addr + 18'd1;
      end else begin
        chk("tie_scr_ok", 32'(scr_ok), 32'd1);
        chk("tie_obj_idle", 32'(obj_ok), 32'd0);
        chk_data("tie_scr_data", scr_data);
        scr_addr = scr_addr + 18'd1;
      end
      expect_obj = ~expect_obj;
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
